bf_out_sequencer: RTL
=====================

# bf_out_sequencer

Downstream neighbour of the butterfly add/sub select mux. It drives the mux select `sw` and captures the add set and then the sub set of each butterfly result pair, using `sw`=0 and then `sw`=1, into a 2-entry vector FIFO. It presents them to the next FFT stage as a valid/ready stream: add half first, then sub half. It converts the butterfly's parallel add/sub output into a serial two-beat stream with backpressure.

## Interface
- `WIDTH`, 10: signed sample width of each re/im lane.
- `DATA_WIDTH`, 16: number of lanes per vector.
- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous active-low reset.
- `bf_valid`  in  1  butterfly add/sub results are valid at the mux inputs. Held high, with data stable, until `bf_ready`.
- `bf_ready`  out  1  one-cycle pulse: the current pair is fully consumed.
- `sw`  out  1  mux select. 0 selects the add set, 1 selects the sub set.
- `mux_re`, `mux_im`  in  signed [WIDTH-1:0] [0:DATA_WIDTH-1]  mux dout.
- `dout_re`, `dout_im`  out  signed [WIDTH-1:0] [0:DATA_WIDTH-1]  FIFO head vector.
- `dout_half`  out  1  0 means the head is an add half, 1 means a sub half.
- `dout_valid`  out  1  head valid.
- `dout_ready`  in  1  downstream accepts the head.

## Operation
- State machine states: `SEL_ADD`, `SEL_SUB`. Reset state is `SEL_ADD`.
- `sw` is a registered copy of the state: 0 in `SEL_ADD`, 1 in `SEL_SUB`.
- push condition: `bf_valid` && (count<2 || pop). Here pop = `dout_valid`&&`dout_ready`.
- In `SEL_ADD`:
  - On push, write `mux_*` and half=0 to the tail, then move to `SEL_SUB`.
  - Otherwise stay in `SEL_ADD` with `sw`=0.
- In `SEL_SUB`:
  - On push, write `mux_*` and half=1 to the tail.
  - Assert `bf_ready` combinationally in that same cycle.
  - Move to `SEL_ADD`.
  - Otherwise stall, holding `sw`=1 with `bf_ready`=0.
- `bf_valid` dropping mid-pair while in `SEL_SUB` is a protocol violation: no push, state held, no recovery required.
- FIFO:
  - 2 entries, count 0..2, 1-bit read and write pointers wrapping 1→0.
  - Simultaneous push and pop at count=2 is legal and count stays 2.
  - Pop at count=0 is impossible because `dout_valid`=0.
- `dout_valid` = (count != 0). `dout_*` and `dout_half` come from the head entry and are undefined-but-stable while `dout_valid`=0.
- Lane data passes through unmodified apart from the optional scaling below.
- Reset values: `sw`=0, `bf_ready`=0, `dout_valid`=0, count=0, both pointers=0, all storage 0, `dout_half`=0.
- Reset asserted mid-pair discards the partial pair and all FIFO contents.

## Timing
- Throughput: one pair per 2 cycles with no backpressure. 100% of the output beats are used.
- Latency: a vector captured at edge N appears on `dout_*` with `dout_valid`=1 in the cycle after N.
- `bf_ready` is high in the `SEL_SUB` push cycle. Upstream may present the next pair in the following cycle, which is already `SEL_ADD`.
- Mux data is sampled one cycle after `sw` changes. The mux is combinational and settles within the cycle.

## Configuration
- `BF_OUT_SCALE_EN` defined:
  - Each lane is stored as (x + 1) >>> 1, computed in WIDTH+1 bits and truncated to WIDTH. This is round-half-up halving for per-stage growth control.
  - Example: 5→3, −5→−2, 511→256, −512→−256.
- Macro absent: lanes are stored bit-exact.

## Test plan
- Streaming, no backpressure:
  - Stimulus: `bf_valid`=1 with add lanes all 7 and sub lanes all −3, `dout_ready`=1.
  - Response: `sw` 0,1,0,1…; `bf_ready` every 2nd cycle; `dout` alternates 7 (half 0) and −3 (half 1), each one cycle after capture.
- Full stall:
  - Stimulus: `dout_ready`=0 for 6 cycles.
  - Response: count reaches 2 after one pair. `sw` then holds 0 and `bf_ready` stays 0 until `dout_ready`=1, after which the next add half is captured in that same cycle.
- Simultaneous push and pop at full:
  - Stimulus: count=2, `dout_ready`=1, `bf_valid`=1.
  - Response: count stays 2, head advances, the new vector goes to the tail, and entry order is preserved.
- Lane independence:
  - Stimulus: lane i add = i, sub = −i−1, on all 16 lanes.
  - Response: output lane i equals i, then −i−1. Extremes 511 and −512 pass unchanged with the macro off.
- Reset mid-pair:
  - Stimulus: assert `rstn`=0 while in `SEL_SUB` with count=1.
  - Response: immediately `sw`=0, `dout_valid`=0, `bf_ready`=0. After release, the first output beat is the add half of the re-presented pair.
- With `BF_OUT_SCALE_EN`:
  - Stimulus: add=5, sub=−5.
  - Response: outputs 3 then −2. Inputs 511 and −512 give 256 and −256.

Source files
------------

// File: rtl/bf_out_sequencer.sv
// ---------------------------------------------------------------------------
// bf_out_sequencer
//
// Sits after the butterfly add/sub select mux. It steers the mux with `sw`
// and captures the add set (sw=0) and then the sub set (sw=1) of each
// butterfly pair into a 2-entry vector FIFO. The FIFO is presented to the
// next FFT stage as a valid/ready stream, add half first, then sub half.
//
// Optional feature macro: BF_OUT_SCALE_EN
//   defined -> every lane is stored as round-half-up halving (x+1)>>>1
//   absent  -> lanes are stored bit-exact
//
// Ports
//   clk, rstn           rising-edge clock, async active-low reset
//   bf_valid            butterfly pair present at mux inputs (held until bf_ready)
//   bf_ready            1-cycle pulse when the sub half of a pair is captured
//   sw                  mux select: 0 = add set, 1 = sub set
//   mux_re, mux_im      mux output lanes
//   dout_re, dout_im    FIFO head vector
//   dout_half           0 = head is an add half, 1 = sub half
//   dout_valid          FIFO head valid
//   dout_ready          downstream accepts head
// ---------------------------------------------------------------------------

// Per-lane storage: two entries of re/im, optional halving on the write side.
module bf_out_lane #(
   parameter int WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    we,
   input  logic                    wptr,
   input  logic                    rptr,
   input  logic signed [WIDTH-1:0] din_re,
   input  logic signed [WIDTH-1:0] din_im,
   output logic signed [WIDTH-1:0] dout_re,
   output logic signed [WIDTH-1:0] dout_im
);

   logic signed [WIDTH-1:0] mem_re [2];
   logic signed [WIDTH-1:0] mem_im [2];

   function automatic logic [WIDTH-1:0] store_val(input logic [WIDTH-1:0] x);
`ifdef BF_OUT_SCALE_EN
      // Sign-extend by one bit so x+1 cannot overflow, then drop the LSB.
      logic [WIDTH:0] ext;
      ext = {x[WIDTH-1], x} + (WIDTH+1)'(1);
      return ext[WIDTH:1];
`else
      return x;
`endif
   endfunction

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 2; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
      end else if (we) begin
         mem_re[wptr] <= store_val(din_re);
         mem_im[wptr] <= store_val(din_im);
      end
   end

   assign dout_re = mem_re[rptr];
   assign dout_im = mem_im[rptr];

endmodule

module bf_out_sequencer #(
   parameter int WIDTH      = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    bf_valid,
   output logic                    bf_ready,
   output logic                    sw,
   input  logic signed [WIDTH-1:0] mux_re [0:DATA_WIDTH-1],
   input  logic signed [WIDTH-1:0] mux_im [0:DATA_WIDTH-1],
   output logic signed [WIDTH-1:0] dout_re [0:DATA_WIDTH-1],
   output logic signed [WIDTH-1:0] dout_im [0:DATA_WIDTH-1],
   output logic                    dout_half,
   output logic                    dout_valid,
   input  logic                    dout_ready
);

   typedef enum logic {
      SEL_ADD = 1'b0,
      SEL_SUB = 1'b1
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] count_q;
   logic       wptr_q, rptr_q;
   logic       half_q [2];
   logic       push, pop;

   assign pop  = dout_valid && dout_ready;
   // A full FIFO can still accept when the head leaves in the same cycle.
   assign push = bf_valid && ((count_q < 2'd2) || pop);

   // The mux select is the state register itself, so it is glitch-free and
   // the mux has a full cycle to settle before the data is sampled.
   assign sw = (state_q == SEL_SUB);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= SEL_ADD;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      bf_ready = 1'b0;
      case (state_q)
         SEL_ADD: begin
            if (push) state_d = SEL_SUB;
         end
         SEL_SUB: begin
            // bf_valid dropping here just stalls; no recovery path.
            if (push) begin
               bf_ready = 1'b1;
               state_d  = SEL_ADD;
            end
         end
         default: state_d = SEL_ADD;
      endcase
   end

   // FIFO control; lane storage lives in the per-lane instances.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q   <= '0;
         wptr_q    <= 1'b0;
         rptr_q    <= 1'b0;
         half_q[0] <= 1'b0;
         half_q[1] <= 1'b0;
      end else begin
         if (push) begin
            half_q[wptr_q] <= (state_q == SEL_SUB);
            wptr_q         <= ~wptr_q;
         end
         if (pop) rptr_q <= ~rptr_q;
         case ({push, pop})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign dout_valid = (count_q != 2'd0);
   assign dout_half  = half_q[rptr_q];

   for (genvar g = 0; g < DATA_WIDTH; g++) begin : g_lane
      bf_out_lane #(.WIDTH(WIDTH)) u_lane (
         .clk     (clk),
         .rstn    (rstn),
         .we      (push),
         .wptr    (wptr_q),
         .rptr    (rptr_q),
         .din_re  (mux_re[g]),
         .din_im  (mux_im[g]),
         .dout_re (dout_re[g]),
         .dout_im (dout_im[g])
      );
   end

endmodule
